// File: rtl/crtc_pkg.sv
// Region encoding, register map and VGA reset timing shared by the CRTC timing sequencer.
package crtc_pkg;

    typedef enum logic [1:0] {
        RGN_ACT  = 2'd0,
        RGN_FP   = 2'd1,
        RGN_SYNC = 2'd2,
        RGN_BP   = 2'd3
    } region_e;

    localparam int unsigned CFG_AW = 3;
    localparam int unsigned CFG_DW = 16;

    localparam logic [CFG_AW-1:0] ADDR_H_ACT  = 3'd0;
    localparam logic [CFG_AW-1:0] ADDR_H_FP   = 3'd1;
    localparam logic [CFG_AW-1:0] ADDR_H_SYNC = 3'd2;
    localparam logic [CFG_AW-1:0] ADDR_H_BP   = 3'd3;
    localparam logic [CFG_AW-1:0] ADDR_V_ACT  = 3'd4;
    localparam logic [CFG_AW-1:0] ADDR_V_FP   = 3'd5;
    localparam logic [CFG_AW-1:0] ADDR_V_SYNC = 3'd6;
    localparam logic [CFG_AW-1:0] ADDR_V_BP   = 3'd7;

    localparam int unsigned VGA_H_ACT  = 640;
    localparam int unsigned VGA_H_FP   = 16;
    localparam int unsigned VGA_H_SYNC = 96;
    localparam int unsigned VGA_H_BP   = 48;
    localparam int unsigned VGA_V_ACT  = 480;
    localparam int unsigned VGA_V_FP   = 10;
    localparam int unsigned VGA_V_SYNC = 2;
    localparam int unsigned VGA_V_BP   = 33;

endpackage

// File: rtl/crtc_axis_sequencer.sv
// One timing axis: walks ACT -> FP -> SYNC -> BP with a per-region loadable position counter.
module crtc_axis_sequencer
    import crtc_pkg::*;
#(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] lengths [4],
    output region_e          state,
    output logic [WIDTH-1:0] count,
    output logic             region_end_c
);

    region_e          state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_cur, last_cnt;

    // A zero length behaves as a one-cycle region.
    always_comb begin
        len_cur      = lengths[state_q];
        last_cnt     = (len_cur == '0) ? '0 : len_cur - WIDTH'(1);
        region_end_c = advance && (count_q == last_cnt);
        state_d      = state_q;
        count_d      = count_q;
        if (region_end_c) begin
            count_d = '0;
            state_d = region_e'(state_q + 2'd1);
        end else if (advance) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RGN_ACT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state = state_q;
    assign count = count_q;

endmodule

// File: rtl/crtc_timing_sequencer.sv
// Programmable CRTC timing: shadowed timing registers applied at frame end, registered sync/enable outputs.
module crtc_timing_sequencer
    import crtc_pkg::*;
#(
    parameter int unsigned HWIDTH     = 11,
    parameter int unsigned VWIDTH     = 10,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned H_ACT_DEF  = VGA_H_ACT,
    parameter int unsigned H_FP_DEF   = VGA_H_FP,
    parameter int unsigned H_SYNC_DEF = VGA_H_SYNC,
    parameter int unsigned H_BP_DEF   = VGA_H_BP,
    parameter int unsigned V_ACT_DEF  = VGA_V_ACT,
    parameter int unsigned V_FP_DEF   = VGA_V_FP,
    parameter int unsigned V_SYNC_DEF = VGA_V_SYNC,
    parameter int unsigned V_BP_DEF   = VGA_V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [CFG_DW-1:0] cfg_data,
    output logic              cfg_pending,
    output logic [HWIDTH-1:0] hcount,
    output logic [VWIDTH-1:0] vcount,
    output logic              display_enable,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start
);

    localparam logic [HWIDTH-1:0] H_DEF [4] = '{HWIDTH'(H_ACT_DEF), HWIDTH'(H_FP_DEF),
                                               HWIDTH'(H_SYNC_DEF), HWIDTH'(H_BP_DEF)};
    localparam logic [VWIDTH-1:0] V_DEF [4] = '{VWIDTH'(V_ACT_DEF), VWIDTH'(V_FP_DEF),
                                               VWIDTH'(V_SYNC_DEF), VWIDTH'(V_BP_DEF)};

    logic [HWIDTH-1:0] h_shadow_q [4], h_shadow_d [4], h_live_q [4], h_live_d [4];
    logic [VWIDTH-1:0] v_shadow_q [4], v_shadow_d [4], v_live_q [4], v_live_d [4];
    logic              pending_q, pending_d;

    logic [HWIDTH-1:0] hcount_q, hcount_d;
    logic [VWIDTH-1:0] vcount_q, vcount_d;
    logic              de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic              line_start_q, line_start_d, frame_start_q, frame_start_d;

    region_e           h_state, v_state;
    logic [HWIDTH-1:0] h_count;
    logic [VWIDTH-1:0] v_count;
    logic              h_end_c, v_end_c, line_end_c, frame_end_c;
    logic              unused_cfg_bits_c;

    crtc_axis_sequencer #(.WIDTH(HWIDTH)) u_h_axis (
        .clk          (clk),
        .reset        (reset),
        .advance      (1'b1),
        .lengths      (h_live_q),
        .state        (h_state),
        .count        (h_count),
        .region_end_c (h_end_c)
    );

    crtc_axis_sequencer #(.WIDTH(VWIDTH)) u_v_axis (
        .clk          (clk),
        .reset        (reset),
        .advance      (line_end_c),
        .lengths      (v_live_q),
        .state        (v_state),
        .count        (v_count),
        .region_end_c (v_end_c)
    );

    assign line_end_c        = (h_state == RGN_BP) && h_end_c;
    assign frame_end_c       = (v_state == RGN_BP) && v_end_c;
    assign unused_cfg_bits_c = ^cfg_data;

    // Live copy takes the pre-write shadow; a colliding write stays pending for the next frame.
    always_comb begin
        h_shadow_d = h_shadow_q;
        v_shadow_d = v_shadow_q;
        h_live_d   = h_live_q;
        v_live_d   = v_live_q;
        pending_d  = pending_q;
        if (frame_end_c && pending_q) begin
            h_live_d  = h_shadow_q;
            v_live_d  = v_shadow_q;
            pending_d = 1'b0;
        end
        if (cfg_we) begin
            pending_d = 1'b1;
            case (cfg_addr)
                ADDR_H_ACT:  h_shadow_d[0] = cfg_data[HWIDTH-1:0];
                ADDR_H_FP:   h_shadow_d[1] = cfg_data[HWIDTH-1:0];
                ADDR_H_SYNC: h_shadow_d[2] = cfg_data[HWIDTH-1:0];
                ADDR_H_BP:   h_shadow_d[3] = cfg_data[HWIDTH-1:0];
                ADDR_V_ACT:  v_shadow_d[0] = cfg_data[VWIDTH-1:0];
                ADDR_V_FP:   v_shadow_d[1] = cfg_data[VWIDTH-1:0];
                ADDR_V_SYNC: v_shadow_d[2] = cfg_data[VWIDTH-1:0];
                ADDR_V_BP:   v_shadow_d[3] = cfg_data[VWIDTH-1:0];
            endcase
        end
    end

    always_comb begin
        hcount_d      = h_count;
        vcount_d      = v_count;
        line_start_d  = (h_state == RGN_ACT) && (h_count == '0);
        frame_start_d = line_start_d && (v_state == RGN_ACT) && (v_count == '0);
        de_d          = (h_state == RGN_ACT) && (v_state == RGN_ACT);
        hsync_d       = (h_state == RGN_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (v_state == RGN_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_shadow_q    <= H_DEF;
            v_shadow_q    <= V_DEF;
            h_live_q      <= H_DEF;
            v_live_q      <= V_DEF;
            pending_q     <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
        end else begin
            h_shadow_q    <= h_shadow_d;
            v_shadow_q    <= v_shadow_d;
            h_live_q      <= h_live_d;
            v_live_q      <= v_live_d;
            pending_q     <= pending_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign cfg_pending    = pending_q;
    assign hcount         = hcount_q;
    assign vcount         = vcount_q;
    assign display_enable = de_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign line_start     = line_start_q;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_crtc_timing_sequencer.sv
// Bench for crtc_timing_sequencer: cycle scoreboard from a position-based model plus frame measurements.
module tb_crtc_timing_sequencer;

    localparam bit HSYNC_POL = 1'b0;
    localparam bit VSYNC_POL = 1'b0;
    localparam int LIMIT     = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_pending;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        display_enable, hsync, vsync, line_start, frame_start;

    // Short default frame height keeps the first shadow transfer within a few thousand cycles.
    crtc_timing_sequencer #(
        .HSYNC_POL (HSYNC_POL), .VSYNC_POL (VSYNC_POL),
        .V_ACT_DEF (4), .V_FP_DEF (1), .V_SYNC_DEF (1), .V_BP_DEF (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_pending    (cfg_pending),
        .hcount         (hcount),
        .vcount         (vcount),
        .display_enable (display_enable),
        .hsync          (hsync),
        .vsync          (vsync),
        .line_start     (line_start),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        de, hs, vs, ls, fs, pend;
    } exp_t;

    typedef struct packed {
        logic [3:0][7:0] h;
        logic [3:0][7:0] v;
        int line_p, frame_p, de_n, hs_n, vs_n;
    } cfg_vec_t;

    exp_t     sb_q[$];
    exp_t     e_chk;
    cfg_vec_t tbl[3];
    int       n_checks = 0;
    int       n_fail   = 0;

    // Reference model: live/shadow lengths and absolute positions within line and frame.
    int m_h[4], m_v[4], s_h[4], s_v[4];
    int hp = 0, vp = 0;
    bit m_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int total(input bit vert);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += eff(vert ? m_v[i] : m_h[i]);
        return s;
    endfunction

    function automatic void locate(input bit vert, input int p, output int r, output int off);
        int base, l;
        base = 0; r = 3; off = 0;
        for (int i = 0; i < 4; i++) begin
            l = eff(vert ? m_v[i] : m_h[i]);
            if (p < base + l) begin
                r = i; off = p - base;
                return;
            end
            base += l;
        end
    endfunction

    function automatic cfg_vec_t mk(input int h0, h1, h2, h3, v0, v1, v2, v3,
                                    input int lp, fp, de, hs, vs);
        cfg_vec_t c;
        c.h[0] = 8'(h0); c.h[1] = 8'(h1); c.h[2] = 8'(h2); c.h[3] = 8'(h3);
        c.v[0] = 8'(v0); c.v[1] = 8'(v1); c.v[2] = 8'(v2); c.v[3] = 8'(v3);
        c.line_p = lp; c.frame_p = fp; c.de_n = de; c.hs_n = hs; c.vs_n = vs;
        return c;
    endfunction

    task automatic model_step();
        exp_t e;
        int hr, ho, vr, vo;
        bit le, fe;
        if (!reset) begin
            e = '0;
            e.hs = ~HSYNC_POL;
            e.vs = ~VSYNC_POL;
            m_h = '{640, 16, 96, 48};
            m_v = '{4, 1, 1, 1};
            s_h = m_h;
            s_v = m_v;
            hp = 0; vp = 0; m_pend = 1'b0;
        end else begin
            locate(1'b0, hp, hr, ho);
            locate(1'b1, vp, vr, vo);
            e.hc = 11'(ho);
            e.vc = 10'(vo);
            e.de = (hr == 0) && (vr == 0);
            e.hs = (hr == 2) ? HSYNC_POL : ~HSYNC_POL;
            e.vs = (vr == 2) ? VSYNC_POL : ~VSYNC_POL;
            e.ls = (hp == 0);
            e.fs = (hp == 0) && (vp == 0);
            le = (hp == total(1'b0) - 1);
            fe = le && (vp == total(1'b1) - 1);
            hp = le ? 0 : hp + 1;
            if (le) vp = fe ? 0 : vp + 1;
            if (fe && m_pend) begin
                m_h = s_h; m_v = s_v; m_pend = 1'b0;
            end
            if (cfg_we) begin
                if (cfg_addr[2]) s_v[cfg_addr[1:0]] = int'(cfg_data[9:0]);
                else             s_h[cfg_addr[1:0]] = int'(cfg_data[10:0]);
                m_pend = 1'b1;
            end
            e.pend = m_pend;
        end
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (sb_q.size() != 0) begin
            e_chk = sb_q.pop_front();
            check("sb_hcount", 32'(hcount), 32'(e_chk.hc));
            check("sb_vcount", 32'(vcount), 32'(e_chk.vc));
            check("sb_display_enable", 32'(display_enable), 32'(e_chk.de));
            check("sb_hsync", 32'(hsync), 32'(e_chk.hs));
            check("sb_vsync", 32'(vsync), 32'(e_chk.vs));
            check("sb_line_start", 32'(line_start), 32'(e_chk.ls));
            check("sb_frame_start", 32'(frame_start), 32'(e_chk.fs));
            check("sb_cfg_pending", 32'(cfg_pending), 32'(e_chk.pend));
        end
    end

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_frame_start(input string name);
        int g;
        g = 0;
        while (!frame_start && g < LIMIT) begin
            @(negedge clk); g++;
        end
        if (g >= LIMIT) timeout_fail(name);
    endtask

    // Called on a frame_start sample; ends on the next frame_start sample.
    task automatic measure_frame(output int fper, output int lper, output int de_n,
                                 output int hs_n, output int vs_n);
        int t;
        t = 0; lper = 0; de_n = 0; hs_n = 0; vs_n = 0;
        forever begin
            if (display_enable)     de_n++;
            if (hsync == HSYNC_POL) hs_n++;
            if (vsync == VSYNC_POL) vs_n++;
            @(negedge clk);
            t++;
            if (line_start && lper == 0) lper = t;
            if (frame_start || t >= LIMIT) break;
        end
        if (t >= LIMIT) timeout_fail("measure_frame");
        fper = t;
    endtask

    // Called on a frame_start sample of a default-timing frame.
    task automatic default_line(input string tag);
        int t;
        t = 0;
        while (hsync != HSYNC_POL && t < 2000) begin
            @(negedge clk); t++;
        end
        check({tag, "_first_hsync"}, 32'(t), 32'd656);
        while (!line_start && t < 2000) begin
            @(negedge clk); t++;
        end
        check({tag, "_line_period"}, 32'(t), 32'd800);
    endtask

    initial begin
        int t, g, fp, lp, de_n, hs_n, vs_n, r, o;
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        tbl[0] = mk(4, 0, 2, 1, 3, 1, 1, 1, 8, 48, 12, 12, 8);
        tbl[1] = mk(3, 2, 1, 2, 2, 0, 3, 1, 8, 56, 6, 7, 24);
        tbl[2] = mk(4, 1, 2, 1, 3, 1, 1, 1, 8, 48, 12, 12, 8);

        repeat (3) @(negedge clk);
        check("rst_hold_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_first_frame_start", 32'(frame_start), 32'd1);
        default_line("rst");

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) write_reg(3'(k), 16'hF800 | 16'(tbl[i].h[k]));
            for (int k = 0; k < 4; k++) write_reg(3'(4 + k), 16'hF800 | 16'(tbl[i].v[k]));
            check("tbl_pending_set", 32'(cfg_pending), 32'd1);
            g = 0;
            while (cfg_pending && g < LIMIT) begin
                @(negedge clk); g++;
            end
            if (g >= LIMIT) timeout_fail("tbl_pending_clear");
            wait_frame_start("tbl_frame_start");
            measure_frame(fp, lp, de_n, hs_n, vs_n);
            check("tbl_line_period", 32'(lp), 32'(tbl[i].line_p));
            check("tbl_frame_period", 32'(fp), 32'(tbl[i].frame_p));
            check("tbl_de_cycles", 32'(de_n), 32'(tbl[i].de_n));
            check("tbl_hsync_cycles", 32'(hs_n), 32'(tbl[i].hs_n));
            check("tbl_vsync_cycles", 32'(vs_n), 32'(tbl[i].vs_n));
        end

        // Mid-frame write of H_ACT=6 on line 1 of a small-timing frame.
        g = 0;
        while (!(vp == 1 && hp == 2) && g < LIMIT) begin
            @(negedge clk); g++;
        end
        if (g >= LIMIT) timeout_fail("midwr_position");
        write_reg(3'd0, 16'd6);
        check("midwr_pending_set", 32'(cfg_pending), 32'd1);
        g = 0;
        while (!line_start && g < 100) begin
            @(negedge clk); g++;
        end
        t = 0; g = 0;
        while (g < 200) begin
            @(negedge clk); t++; g++;
            if (line_start) begin
                check("midwr_old_line_period", 32'(t), 32'd8);
                t = 0;
                if (frame_start) break;
            end
        end
        if (g >= 200) timeout_fail("midwr_frame_end");
        check("midwr_pending_clear", 32'(cfg_pending), 32'd0);
        measure_frame(fp, lp, de_n, hs_n, vs_n);
        check("midwr_new_line_period", 32'(lp), 32'd10);
        check("midwr_new_frame_period", 32'(fp), 32'd60);

        // Write H_ACT=5 exactly on the frame-end cycle.
        g = 0;
        while (!(hp == total(1'b0) - 1 && vp == total(1'b1) - 1) && g < LIMIT) begin
            @(negedge clk); g++;
        end
        if (g >= LIMIT) timeout_fail("coll_position");
        write_reg(3'd0, 16'd5);
        check("coll_pending_set", 32'(cfg_pending), 32'd1);
        wait_frame_start("coll_frame_start");
        check("coll_pending_kept", 32'(cfg_pending), 32'd1);
        measure_frame(fp, lp, de_n, hs_n, vs_n);
        check("coll_old_line_period", 32'(lp), 32'd10);
        check("coll_old_frame_period", 32'(fp), 32'd60);
        check("coll_pending_clear", 32'(cfg_pending), 32'd0);
        measure_frame(fp, lp, de_n, hs_n, vs_n);
        check("coll_new_line_period", 32'(lp), 32'd9);
        check("coll_new_frame_period", 32'(fp), 32'd54);

        // Pending write, then a one-cycle reset during V_SYNC.
        write_reg(3'd0, 16'd7);
        check("mrst_pending_set", 32'(cfg_pending), 32'd1);
        g = 0;
        locate(1'b1, vp, r, o);
        while (r != 2 && g < LIMIT) begin
            @(negedge clk); g++;
            locate(1'b1, vp, r, o);
        end
        if (g >= LIMIT) timeout_fail("mrst_position");
        check("mrst_vsync_region_line", 32'(o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_in_reset_frame_start", 32'(frame_start), 32'd0);
        check("mrst_pending_dropped", 32'(cfg_pending), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_frame_start", 32'(frame_start), 32'd1);
        default_line("mrst");
        check("mrst_pending_still_clear", 32'(cfg_pending), 32'd0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
